// File: rtl/single_port_ram_arbiter_if.sv
// single_port_ram_arbiter_if: one requester's request/response channel to the shared RAM
interface single_port_ram_arbiter_if #(
   parameter int WIDTH         = 8,
   parameter int ADDRESS_WIDTH = 4
);
   logic                     request_valid;
   logic                     request_ready;
   logic                     request_write;
   logic [ADDRESS_WIDTH-1:0] request_address;
   logic [WIDTH-1:0]         request_write_data;
   logic                     response_valid;
   logic [WIDTH-1:0]         response_read_data;

   modport master (
      output request_valid, request_write, request_address, request_write_data,
      input  request_ready, response_valid, response_read_data
   );

   modport slave (
      input  request_valid, request_write, request_address, request_write_data,
      output request_ready, response_valid, response_read_data
   );
endinterface

// File: rtl/single_port_ram_arbiter.sv
// single_port_ram_arbiter: round-robin sharing of one single-port RAM between two requesters
module single_port_ram_arbiter #(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 16,
   parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
   input logic                        clock,
   input logic                        resetn,
   single_port_ram_arbiter_if.slave   port0,
   single_port_ram_arbiter_if.slave   port1
);
   logic                     last_grant;
   logic                     response_pending;
   logic                     response_port;
   logic                     grant0;
   logic                     grant1;
   logic                     access_enable;
   logic                     ram_write;
   logic [ADDRESS_WIDTH-1:0] ram_address;
   logic [WIDTH-1:0]         ram_write_data;
   logic [WIDTH-1:0]         read_data;

   // port 1 wins when alone or when port 0 took the most recent transfer
   always_comb begin
      grant1         = port1.request_valid & (~port0.request_valid | ~last_grant);
      grant0         = port0.request_valid & ~grant1;
      access_enable  = grant0 | grant1;
      ram_write      = grant1 ? port1.request_write      : port0.request_write;
      ram_address    = grant1 ? port1.request_address    : port0.request_address;
      ram_write_data = grant1 ? port1.request_write_data : port0.request_write_data;
   end

   assign port0.request_ready      = grant0;
   assign port1.request_ready      = grant1;
   assign port0.response_valid     = response_pending & ~response_port;
   assign port1.response_valid     = response_pending & response_port;
   assign port0.response_read_data = read_data;
   assign port1.response_read_data = read_data;

   // priority moves only on a transfer; a read marks its port for the next-cycle response
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         last_grant       <= 1'b1;
         response_pending <= 1'b0;
         response_port    <= 1'b0;
      end else begin
         if (access_enable) last_grant <= grant1;
         response_pending <= access_enable & ~ram_write;
         response_port    <= grant1;
      end
   end

   single_port_ram #(
      .WIDTH         (WIDTH),
      .DEPTH         (DEPTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH)
   ) ram (
      .clock         (clock),
      .access_enable (access_enable),
      .write         (ram_write),
      .address       (ram_address),
      .write_data    (ram_write_data),
      .read_data     (read_data)
   );
endmodule

// single_port_ram: one access per cycle, registered read data held between reads
module single_port_ram #(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 16,
   parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
   input  logic                     clock,
   input  logic                     access_enable,
   input  logic                     write,
   input  logic [ADDRESS_WIDTH-1:0] address,
   input  logic [WIDTH-1:0]         write_data,
   output logic [WIDTH-1:0]         read_data
);
   logic [WIDTH-1:0] memory [DEPTH];

   // write updates the array; read loads the output register, which otherwise holds
   always_ff @(posedge clock) begin
      if (access_enable) begin
         if (write) memory[address] <= write_data;
         else read_data <= memory[address];
      end
   end
endmodule
